// File: rtl/dlbf_coeffs_pkg.sv
// Shared types and width helpers for the DLBF coefficient RAM-to-AXI4-Stream reader.
package dlbf_coeffs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int inflight_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/dlbf_coeffs_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
module dlbf_coeffs_sync_fifo import dlbf_coeffs_pkg::*; #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = fifo_count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    assign wr_ok_s = wr_en & ~flush & (count_r != CW'(FIFO_DEPTH));
    assign rd_ok_s = rd_en & ~flush & ~empty;
    assign empty   = (count_r == '0);
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; flush wins over any concurrent access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + CW'(wr_ok_s) - CW'(rd_ok_s);
        end
    end

endmodule

// File: rtl/dlbf_coeffs_ram2axis_stream.sv
// Streams coefficients from a circular RAM window to AXI4-Stream in blocks, with
// credit-based backpressure, counted or free-running iteration and clean abort.
module dlbf_coeffs_ram2axis_stream import dlbf_coeffs_pkg::*; #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 16,
    parameter int CNT_WIDTH        = 12,
    parameter int RAM_READ_LATENCY = 4,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                    m_axis_clk,
    input  logic                    m_axis_rst_n,
    input  logic                    go,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   rollover_addr,
    input  logic [CNT_WIDTH-1:0]    block_size,
    input  logic [CNT_WIDTH-1:0]    niter,
    output logic                    ram_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    busy,
    output logic                    done
);

    localparam int LAT = RAM_READ_LATENCY;
    localparam int CW  = fifo_count_width(FIFO_DEPTH);
    localparam int IW  = inflight_width(LAT);
    localparam int OW  = CW + 1;
    localparam int PW  = 2 * CNT_WIDTH;

    state_t                  state_r;
    logic                    go_q_r, busy_r, done_r, abort_r, hold_r;
    logic [ADDR_WIDTH-1:0]   base_r, last_addr_r, addr_r;
    logic [CNT_WIDTH-1:0]    bs_r, niter_r, beat_cnt_r, iter_cnt_r;
    logic [PW-1:0]           total_r, issued_r;
    logic [LAT-1:0]          vld_sr_r;
    logic [IW-1:0]           inflight_r;
    logic [CW-1:0]           fifo_count_s;
    logic [DATA_WIDTH-1:0]   fifo_dout_s;
    logic                    fifo_empty_s;
    logic                    go_edge_s, counted_s, can_issue_s, ram_en_s, last_read_s;
    logic                    tvalid_s, hs_s, final_hs_s, abort_req_s;
    logic [CNT_WIDTH-1:0]    bs_last_s;

    assign go_edge_s   = go & ~go_q_r & (state_r == IDLE) & (|block_size) & (|rollover_addr);
    assign counted_s   = |niter_r;
    // Everything already in the FIFO or still in the RAM pipe owns a FIFO slot.
    assign can_issue_s = (OW'(fifo_count_s) + OW'(inflight_r)) < OW'(FIFO_DEPTH);
    assign ram_en_s    = (state_r == RUN) & ~abort & can_issue_s & (~counted_s | (issued_r < total_r));
    assign last_read_s = ram_en_s & counted_s & (issued_r == total_r - PW'(1));

    assign bs_last_s   = bs_r - CNT_WIDTH'(1);
    assign tvalid_s    = busy_r & ~fifo_empty_s & (~abort_r | hold_r);
    assign hs_s        = tvalid_s & m_axis_tready;
    assign final_hs_s  = hs_s & counted_s & (iter_cnt_r == niter_r - CNT_WIDTH'(1)) & (beat_cnt_r == bs_last_s);
    assign abort_req_s = abort & ~abort_r & busy_r & ~final_hs_s;

    assign ram_en        = ram_en_s;
    assign ram_addr      = addr_r;
    assign m_axis_tvalid = tvalid_s;
    assign m_axis_tlast  = tvalid_s & (beat_cnt_r == bs_last_s);
    assign m_axis_tdata  = tvalid_s ? fifo_dout_s : {DATA_WIDTH{1'b0}};
    assign m_axis_tkeep  = tvalid_s ? {(DATA_WIDTH/8){1'b1}} : {(DATA_WIDTH/8){1'b0}};
    assign busy          = busy_r;
    assign done          = done_r;

    dlbf_coeffs_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (m_axis_clk),
        .rst_n   (m_axis_rst_n),
        .flush   (abort_r & ~hold_r),
        .wr_en   (vld_sr_r[LAT-1] & ~abort_r),
        .wr_data (ram_dout),
        .rd_en   (hs_s),
        .rd_data (fifo_dout_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Read side: address walk with wrap, issue count and RAM latency pipe.
    always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
        if (!m_axis_rst_n) begin
            addr_r     <= '0;
            issued_r   <= '0;
            vld_sr_r   <= '0;
            inflight_r <= '0;
        end else begin
            vld_sr_r[0] <= ram_en_s;
            for (int i = 1; i < LAT; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
            end
            inflight_r <= inflight_r + IW'(ram_en_s) - IW'(vld_sr_r[LAT-1]);
            if (go_edge_s) begin
                addr_r   <= base_addr;
                issued_r <= '0;
            end else if (ram_en_s) begin
                addr_r   <= (addr_r == last_addr_r) ? base_r : addr_r + ADDR_WIDTH'(1);
                issued_r <= issued_r + PW'(1);
            end
        end
    end

    // Control FSM with config capture, beat/iteration counters and abort hold.
    always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
        if (!m_axis_rst_n) begin
            state_r     <= IDLE;
            go_q_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            abort_r     <= 1'b0;
            hold_r      <= 1'b0;
            base_r      <= '0;
            last_addr_r <= '0;
            bs_r        <= '0;
            niter_r     <= '0;
            total_r     <= '0;
            beat_cnt_r  <= '0;
            iter_cnt_r  <= '0;
        end else begin
            go_q_r <= go;
            if (hs_s) begin
                if (beat_cnt_r == bs_last_s) begin
                    beat_cnt_r <= '0;
                    iter_cnt_r <= iter_cnt_r + CNT_WIDTH'(1);
                end else begin
                    beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
                end
            end
            // A beat presented when abort arrives must survive until accepted.
            if (abort_req_s) begin
                abort_r <= 1'b1;
                hold_r  <= tvalid_s & ~m_axis_tready;
            end else if (hs_s) begin
                hold_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (go_edge_s) begin
                        base_r      <= base_addr;
                        last_addr_r <= base_addr + rollover_addr - ADDR_WIDTH'(1);
                        bs_r        <= block_size;
                        niter_r     <= niter;
                        total_r     <= PW'(block_size) * PW'(niter);
                        beat_cnt_r  <= '0;
                        iter_cnt_r  <= '0;
                        busy_r      <= 1'b1;
                        state_r     <= RUN;
                    end
                end
                RUN: begin
                    if (abort_req_s || last_read_s) state_r <= DRAIN;
                end
                DRAIN: begin
                    if ((inflight_r == '0) && fifo_empty_s && !hold_r) begin
                        state_r <= abort_r ? IDLE : DONE;
                        done_r  <= ~abort_r;
                        busy_r  <= 1'b0;
                        abort_r <= 1'b0;
                        hold_r  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!go) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlbf_coeffs_ram2axis_stream.sv
// Directed bench: a beat-index model predicts every accepted beat from the run configuration.
module tb_dlbf_coeffs_ram2axis_stream;

    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, go, abort, tready;
    logic [15:0] base_addr, rollover_addr, ram_addr;
    logic [11:0] block_size, niter;
    logic        ram_en, tvalid, tlast, busy, done;
    logic [63:0] ram_dout, tdata;
    logic [7:0]  tkeep;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    logic [15:0] cfg_base;
    int          cfg_roll, cfg_bs, limit, exp_k;
    int          first_en_cyc, last_hs_cyc, done_rise_cyc, go_cyc;
    logic [63:0] cap_data [16];
    logic        cap_last [16];
    logic        prev_hold, prev_last, prev_done;
    logic [63:0] prev_data;
    logic [15:0] apipe [LAT];

    dlbf_coeffs_ram2axis_stream #(
        .DATA_WIDTH(64), .ADDR_WIDTH(16), .CNT_WIDTH(12),
        .RAM_READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .m_axis_clk(clk), .m_axis_rst_n(rst_n), .go(go), .abort(abort),
        .base_addr(base_addr), .rollover_addr(rollover_addr),
        .block_size(block_size), .niter(niter),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] word(input logic [15:0] a);
        return {a, ~a, 16'hBEEF, a ^ 16'h1234};
    endfunction

    // RAM read port with LAT cycles from address to data.
    always @(posedge clk) begin
        apipe[0] <= ram_addr;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign ram_dout = word(apipe[LAT-1]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every handshake is checked against the beat-index model.
    always @(negedge clk) begin
        logic [15:0] off;
        logic [15:0] a;
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            check("tkeep", {56'd0, tkeep}, tvalid ? 64'hFF : 64'h0);
            if (prev_hold) begin
                check("hold_valid", {63'd0, tvalid}, 64'd1);
                check("hold_data", tdata, prev_data);
                check("hold_last", {63'd0, tlast}, {63'd0, prev_last});
            end
            if (abort) check("abort_no_read", {63'd0, ram_en}, 64'd0);
            if (ram_en) begin
                if (first_en_cyc < 0) first_en_cyc = cyc;
                off = ram_addr - cfg_base;
                check("addr_window", {63'd0, (int'(off) < cfg_roll)}, 64'd1);
            end
            if (tvalid && tready) begin
                if (limit != 0 && exp_k >= limit) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL extra_beat: got beat index %0d, expected at most %0d beats", exp_k, limit);
                end else begin
                    a = cfg_base + 16'(exp_k % cfg_roll);
                    check("beat_data", tdata, word(a));
                    check("beat_last", {63'd0, tlast}, {63'd0, ((exp_k % cfg_bs) == cfg_bs - 1)});
                    if (exp_k < 16) begin
                        cap_data[exp_k] = tdata;
                        cap_last[exp_k] = tlast;
                    end
                    exp_k++;
                    if (limit != 0 && exp_k == limit) last_hs_cyc = cyc;
                end
            end
            if (done && !prev_done) done_rise_cyc = cyc;
            prev_hold = tvalid & ~tready;
            prev_data = tdata;
            prev_last = tlast;
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] b, input logic [15:0] r, input logic [11:0] bs, input logic [11:0] n);
        cfg_base = b; cfg_roll = int'(r); cfg_bs = int'(bs);
        limit = int'(bs) * int'(n);
        exp_k = 0; first_en_cyc = -1; last_hs_cyc = -100; done_rise_cyc = -100;
        base_addr = b; rollover_addr = r; block_size = bs; niter = n;
        go = 1'b0;
        tick();
        go = 1'b1;
        go_cyc = cyc;
    endtask

    task automatic run_to_done(input int budget, input bit rnd, input string tag);
        int c;
        c = 0;
        while (!done && c < budget) begin
            tick();
            tready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            c++;
        end
        @(negedge clk);
        #1;
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_beats"}, 64'(exp_k), 64'(limit));
        check({tag, "_done_latency"}, 64'(done_rise_cyc - last_hs_cyc), 64'd2);
        tready = 1'b1;
        go = 1'b0;
        tick();
        tick();
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k0;
        logic flag_a, flag_b;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; tready = 1'b1;
        base_addr = '0; rollover_addr = '0; block_size = '0; niter = '0;
        cfg_base = '0; cfg_roll = 1; cfg_bs = 1; limit = 0; exp_k = 0;
        first_en_cyc = -1; last_hs_cyc = -100; done_rise_cyc = -100;
        repeat (3) tick();
        check("reset_ctrl", {59'd0, ram_en, tvalid, tlast, busy, done}, 64'd0);
        check("reset_data", tdata, 64'd0);
        check("reset_keep_addr", {40'd0, tkeep, ram_addr}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: counted run, full throughput, first-beat latency
        start(16'h0010, 16'd8, 12'd4, 12'd3);
        c = 0;
        while (!tvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t1_first_valid_latency", 64'(cyc - go_cyc), 64'(2 + LAT));
        check("t1_first_en_latency", 64'(first_en_cyc - go_cyc), 64'd1);
        run_to_done(100, 1'b0, "t1");
        check("t1_pin_beat1", cap_data[0], 64'h0010_FFEF_BEEF_1224);
        check("t1_pin_beat8", cap_data[7], 64'h0017_FFE8_BEEF_1223);
        check("t1_pin_beat9_wrap", cap_data[8], 64'h0010_FFEF_BEEF_1224);
        check("t1_pin_lasts", {60'd0, cap_last[3], cap_last[4], cap_last[7], cap_last[11]}, 64'b1011);

        // 2: same run under random backpressure
        start(16'h0010, 16'd8, 12'd4, 12'd3);
        run_to_done(2000, 1'b1, "t2");
        check("t2_pin_beat12", cap_data[11], 64'h0013_FFEC_BEEF_1227);

        // 3: free-running, block_size 5, odd rollover
        start(16'h0020, 16'd7, 12'd5, 12'd0);
        repeat (20) tick();
        k0 = exp_k;
        flag_a = 1'b0;
        flag_b = 1'b0;
        repeat (1000) begin
            tick();
            flag_a = flag_a | done;
            flag_b = flag_b | ~busy;
        end
        check("t3_throughput", 64'(exp_k - k0), 64'd1000);
        check("t3_no_done", {63'd0, flag_a}, 64'd0);
        check("t3_busy_held", {63'd0, flag_b}, 64'd0);
        check("t3_pin_beat8_wrap", cap_data[7], 64'h0020_FFDF_BEEF_1214);
        check("t3_pin_lasts", {61'd0, cap_last[4], cap_last[7], cap_last[9]}, 64'b101);
        abort = 1'b1;
        c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        check("t3_abort_idle", {62'd0, busy, done}, 64'd0);
        abort = 1'b0;
        go = 1'b0;
        tick();

        // 4: abort while beat 6 is held under tready=0
        start(16'h0040, 16'd16, 12'd8, 12'd2);
        c = 0;
        while (exp_k < 5 && c < 100) begin
            tick();
            c++;
        end
        tready = 1'b0;
        c = 0;
        while (!tvalid && c < 20) begin
            tick();
            c++;
        end
        abort = 1'b1;
        limit = 6;
        repeat (3) tick();
        check("t4_held_valid", {63'd0, tvalid}, 64'd1);
        tready = 1'b1;
        c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        check("t4_idle_bound", 64'(c <= LAT + DEPTH), 64'd1);
        check("t4_beats", 64'(exp_k), 64'd6);
        check("t4_pin_beat6", cap_data[5], 64'h0045_FFBA_BEEF_1271);
        repeat (5) tick();
        check("t4_quiet", {61'd0, tvalid, busy, done}, 64'd0);
        abort = 1'b0;
        go = 1'b0;
        tick();

        // 5: asynchronous reset mid-run, then restart
        start(16'h0010, 16'd8, 12'd4, 12'd3);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("t5_reset_ctrl", {59'd0, ram_en, tvalid, tlast, busy, done}, 64'd0);
        check("t5_reset_data", tdata, 64'd0);
        check("t5_reset_keep_addr", {40'd0, tkeep, ram_addr}, 64'd0);
        go = 1'b0;
        tick();
        rst_n = 1'b1;
        start(16'h0010, 16'd8, 12'd4, 12'd3);
        run_to_done(100, 1'b0, "t5");
        check("t5_pin_beat1", cap_data[0], 64'h0010_FFEF_BEEF_1224);
        check("t5_pin_last4", {62'd0, cap_last[2], cap_last[3]}, 64'b01);

        // 6: degenerate configurations are ignored
        for (int t = 0; t < 2; t++) begin
            base_addr = 16'h0010;
            rollover_addr = (t == 0) ? 16'd8 : 16'd0;
            block_size = (t == 0) ? 12'd0 : 12'd4;
            niter = 12'd1;
            go = 1'b0;
            tick();
            go = 1'b1;
            flag_a = 1'b0;
            repeat (10) begin
                tick();
                flag_a = flag_a | busy | ram_en | tvalid;
            end
            check((t == 0) ? "t6_bs0_idle" : "t6_roll0_idle", {63'd0, flag_a}, 64'd0);
            go = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
